// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential RISC-V multiplier: op encodings, FSM states, operand signedness.
package seq_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  typedef struct packed {
    logic a_sgn;
    logic b_sgn;
  } sgn_t;

  // MUL only keeps the low half, which is sign-agnostic, so it runs unsigned.
  function automatic sgn_t op_sign(input logic [1:0] op);
    sgn_t s;
    s.a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    s.b_sgn = (op == OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/seq_mul_dp.sv
// Shift-add datapath: {carry,hi,lo} accumulator, XLEN+1-bit adder and final sign fix; one iteration per step.
// No backpressure of its own, the FSM sequences it; SEQ_MUL_EARLY_OUT_EN adds the early-out barrel shift.
module seq_mul_dp
  import seq_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                load,
  input  logic [XLEN-1:0]     mcand,
  input  logic [XLEN-1:0]     mplier,
  input  logic                step,
`ifdef SEQ_MUL_EARLY_OUT_EN
  input  logic                skip,
  input  logic [$clog2(XLEN):0] cnt,
  output logic                rem_zero,
`endif
  input  logic                neg,
  output logic [2*XLEN-1:0]   prod_fix
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   addend;
  logic [XLEN:0]     sum;

  assign addend   = acc_q[0] ? mcand_q : '0;
  assign sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, addend};
  assign prod_fix = neg ? -acc_q : acc_q;

`ifdef SEQ_MUL_EARLY_OUT_EN
  localparam int SW = $clog2(XLEN) + 1;
  logic [XLEN-1:0] rem_mask;
  logic [SW-1:0]   shamt;

  // Multiplier bits not yet consumed sit in lo[XLEN-1-cnt:0].
  assign rem_mask = {XLEN{1'b1}} >> cnt;
  assign rem_zero = (acc_q[XLEN-1:0] & rem_mask) == '0;
  assign shamt    = SW'(XLEN) - cnt;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
    end else if (load) begin
      acc_q   <= {{XLEN{1'b0}}, mplier};
      mcand_q <= mcand;
    end else if (step) begin
      acc_q <= {sum, acc_q[XLEN-1:1]};
`ifdef SEQ_MUL_EARLY_OUT_EN
    end else if (skip) begin
      acc_q <= acc_q >> shamt;
`endif
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU), done XLEN+1 cycles after accept (SEQ_MUL_EARLY_OUT_EN: msb(|b|)+3).
// Accepts on start_i && ready_o; no queueing while busy; flush_i aborts without done_o.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o,
  output logic [2*XLEN-1:0] prod_o
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic              neg_q;
  logic              accept;
  logic              step;
  sgn_t              sgn;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] prod_fix;
`ifdef SEQ_MUL_EARLY_OUT_EN
  logic              skip;
  logic              rem_zero;
`endif

  assign sgn     = op_sign(op_i);
  assign a_neg   = sgn.a_sgn & a_i[XLEN-1];
  assign b_neg   = sgn.b_sgn & b_i[XLEN-1];
  assign a_mag   = a_neg ? -a_i : a_i;
  assign b_mag   = b_neg ? -b_i : b_i;
  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == CALC) || (state_q == FIX);
  assign accept  = start_i && ready_o && !flush_i;

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
`ifdef SEQ_MUL_EARLY_OUT_EN
    skip    = 1'b0;
`endif
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
`ifdef SEQ_MUL_EARLY_OUT_EN
        end else if (rem_zero) begin
          skip    = 1'b1;
          state_d = FIX;
`endif
        end else begin
          step = 1'b1;
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      prod_o   <= '0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      if (accept) begin
        op_q  <= op_i;
        neg_q <= a_neg ^ b_neg;
        cnt_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == FIX) && !flush_i) begin
        prod_o   <= prod_fix;
        result_o <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        done_o   <= 1'b1;
      end
    end
  end

  seq_mul_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (accept),
    .mcand    (a_mag),
    .mplier   (b_mag),
    .step     (step),
`ifdef SEQ_MUL_EARLY_OUT_EN
    .skip     (skip),
    .cnt      (cnt_q),
    .rem_zero (rem_zero),
`endif
    .neg      (neg_q),
    .prod_fix (prod_fix)
  );

endmodule
